// File: rtl/memory_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter, bundled with
// an arbiter-side (slave) view and a driver-side (master) view.
interface memory_arbiter_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        memerr;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, ramready,
    output ihit, dhit, imemload, dmemload,
    output ramREN, ramWEN, ramaddr, ramstore, memerr
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, ramready,
    input  ihit, dhit, imemload, dmemload,
    input  ramREN, ramWEN, ramaddr, ramstore, memerr
  );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins over fetch; each access ends in a one-cycle hit, or an error hit on timeout.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic             CLK,
  input logic             nRST,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IACC, DACC, HIT} state_e;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] ERR_WORD = 32'hBAD1BAD1;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        data_q, data_d;
  logic        memerr_q, memerr_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      memerr_q <= memerr_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    data_d   = data_q;
    memerr_d = memerr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.dmemREN || bus.dmemWEN) begin
          state_d = DACC;
          addr_d  = bus.dmemaddr;
          store_d = bus.dmemstore;
          wr_d    = bus.dmemWEN;
          data_d  = 1'b1;
          cnt_d   = '0;
        end else if (bus.imemREN) begin
          state_d = IACC;
          addr_d  = bus.imemaddr;
          store_d = bus.dmemstore;
          wr_d    = 1'b0;
          data_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      IACC, DACC: begin
        // ramready beats a coinciding timeout and leaves memerr alone.
        if (bus.ramready) begin
          state_d = HIT;
          if (state_q == IACC)  iload_d = bus.ramload;
          else if (!wr_q)       dload_d = bus.ramload;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = HIT;
          memerr_d = 1'b1;
          if (state_q == IACC)  iload_d = ERR_WORD;
          else                  dload_d = ERR_WORD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HIT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes come only from latched state; address and store data simply
  // hold between accesses because their registers only load on a grant.
  assign bus.ramREN   = (state_q == IACC) || (state_q == DACC && !wr_q);
  assign bus.ramWEN   = (state_q == DACC) && wr_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ihit     = (state_q == HIT) && !data_q;
  assign bus.dhit     = (state_q == HIT) && data_q;
  assign bus.imemload = iload_q;
  assign bus.dmemload = dload_q;
  assign bus.memerr   = memerr_q;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles an access waits for ramready before abort (legal 2..255).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port imemREN  input  1  instruction fetch request.
REQ-005 The block SHALL have port imemaddr  input  32  fetch address.
REQ-006 The block SHALL have port dmemREN  input  1  data read request.
REQ-007 The block SHALL have port dmemWEN  input  1  data write request.
REQ-008 The block SHALL have port dmemaddr  input  32  data address.
REQ-009 The block SHALL have port dmemstore  input  32  write data.
REQ-010 The block SHALL have port ihit  output  1  one-cycle fetch-complete pulse.
REQ-011 The block SHALL have port dhit  output  1  one-cycle data-complete pulse.
REQ-012 The block SHALL have port imemload  output  32  fetched word; valid while ihit=1.
REQ-013 The block SHALL have port dmemload  output  32  read word; valid while dhit=1.
REQ-014 The block SHALL have port ramREN, ramWEN  output  1 each  RAM strobes.
REQ-015 The block SHALL have port ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-016 The block SHALL have port ramload  input  32  RAM read data; valid when ramready=1.
REQ-017 The block SHALL have port ramready  input  1  RAM access-complete pulse.
REQ-018 The block SHALL have port memerr  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have four states: IDLE, IACC, DACC and HIT.
REQ-020 IDLE transitions: (dmemREN|dmemWEN) -> DACC; else imemREN -> IACC; else stay in IDLE. Data SHALL always take priority over fetch.
REQ-021 On leaving IDLE, the block SHALL latch the address, store data and op type (write if dmemWEN=1, else read; WEN wins if both are set) into internal registers.
REQ-022 In IACC/DACC, ramaddr, ramstore, ramREN and ramWEN SHALL be driven from the latched registers only; requester input changes mid-access SHALL be ignored.
REQ-023 Outside IACC/DACC, ramREN=ramWEN=0, and ramaddr/ramstore SHALL hold their last values.
REQ-024 In IACC/DACC, ramready=1 SHALL capture ramload into the matching load register (DACC-read only; a write captures nothing) and transition to HIT.
REQ-025 A timeout counter SHALL clear on entry to IACC/DACC and increment each cycle without ramready. When it reaches TIMEOUT-1 without ramready, the block SHALL set memerr=1, load 32'hBAD1BAD1 into the matching load register, and transition to HIT.
REQ-026 If ramready and timeout coincide, ramready SHALL win and memerr SHALL be unchanged.
REQ-027 HIT SHALL last exactly one cycle. ihit=1 if the access was IACC, dhit=1 if DACC, never both. HIT SHALL always transition to IDLE without granting, so a requester that drops its request on the edge after the hit is not re-served.
REQ-028 Minimum latency SHALL be: request sampled in IDLE at edge 0, RAM strobes in cycle 1, hit in cycle k+1 where k is the first cycle ramready=1 (k>=1).
REQ-029 ramready in IDLE or HIT SHALL be ignored.
REQ-030 memerr SHALL stay 1 until reset.
REQ-031 imemload/dmemload SHALL hold their values between hits.

Reset
REQ-032 nRST=0 SHALL immediately force state=IDLE, ihit=dhit=0, ramREN=ramWEN=0, ramaddr=ramstore=0, imemload=dmemload=0, timeout counter=0, memerr=0.
REQ-033 Reset asserted mid-access SHALL abort the access with no hit pulse. After release, the block SHALL re-arbitrate from IDLE on the first rising edge.

Verification
REQ-034 Fetch: imemREN=1, imemaddr=0x40, ramready at cycle 3 with ramload=0x8C220004 -> ramREN=1/ramaddr=0x40 in cycles 1-3; ihit=1 and imemload=0x8C220004 in cycle 4 only.
REQ-035 Priority: imemREN=1 and dmemREN=1 (dmemaddr=0x100) together in IDLE -> DACC first with ramaddr=0x100, dhit before any ihit; fetch granted in the cycle after HIT→IDLE.
REQ-036 Write: dmemWEN=1, dmemaddr=0x200, dmemstore=0xDEADBEEF; inputs changed to 0 during the access; ramready at cycle 2 -> ramWEN=1/ramstore=0xDEADBEEF held through cycle 2, dhit in cycle 3, dmemload unchanged.
REQ-037 Timeout: TIMEOUT=4, data read, ramready never asserted -> strobes in cycles 1-4, dhit in cycle 5 with dmemload=0xBAD1BAD1, memerr=1 thereafter.
REQ-038 Reset mid-access: nRST=0 during IACC cycle 2 -> ramREN drops immediately, no ihit; after release with imemREN=1 -> new fetch starts on the next edge.
REQ-039 Held request: requester keeps dmemREN=1 through the HIT cycle and drops it at the following edge -> exactly one dhit, no second RAM access.
